// File: rtl/eth_fifo_pkg.sv
// Shared constants and helpers for the Ethernet MAC FIFO blocks.
// - DefDataWidth / DefMemDepth : default word width and RAM depth
// - AfullMargin                : free RAM slots left when almost-full asserts
// - ptr_width()                : pointer width (one extra bit to tell full from empty)
package eth_fifo_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefMemDepth  = 64;
    localparam int unsigned AfullMargin  = 8;

    function automatic int unsigned ptr_width(input int unsigned addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for an external dual-port block RAM with a
// registered, enable-gated read port. Owns pointers, flags and occupancy and
// runs a two-stage read pipeline (RAM read register + output register) so the
// consumer sees a bubble-free valid/ready stream. Capacity is MEM_DEPTH+2.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_wr_en, i_wr_data       push request and data
//   o_full, o_almost_full    RAM occupancy flags (registered)
//   o_overflow               one-cycle pulse after a dropped push
//   o_rd_valid, i_rd_ready   output stream handshake
//   o_rd_data                output word (registered)
//   o_count                  words held in RAM + stage 1 + output stage
//   o_mem_*                  RAM controls (combinational from registers/inputs)
//   i_mem_rd_data            RAM read register, updates one edge after o_mem_rd_en
module sync_fifo_ctrl
    import eth_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned MEM_DEPTH    = DefMemDepth,
    parameter int unsigned ADDR_BITS    = $clog2(MEM_DEPTH),
    parameter int unsigned AFULL_THRESH = MEM_DEPTH - AfullMargin
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic                  o_overflow,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [ADDR_BITS+1:0]  o_count,
    output logic                  o_mem_wr_en,
    output logic                  o_mem_rd_en,
    output logic                  o_mem_full,
    output logic [ADDR_BITS-1:0]  o_mem_wr_addr,
    output logic [ADDR_BITS-1:0]  o_mem_rd_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);

    localparam int unsigned PtrW = ptr_width(ADDR_BITS);
    localparam int unsigned CntW = ADDR_BITS + 2;
    localparam logic [PtrW-1:0] DepthPtr = PtrW'(MEM_DEPTH);
    localparam logic [PtrW-1:0] AfullPtr = PtrW'(AFULL_THRESH);

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       mem_cnt, mem_cnt_d;
    logic                  p1_valid_q, p1_valid_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  full_q, afull_q, ovf_q;
    logic [CntW-1:0]       count_q, count_d;

    logic push_ok, pop, adv, fetch;

    always_comb begin
        mem_cnt = wr_ptr_q - rd_ptr_q;
        push_ok = i_wr_en & ~full_q;
        pop     = rd_valid_q & i_rd_ready;
        // Stage 1 moves forward when the output stage is empty or being drained.
        adv     = p1_valid_q & (~rd_valid_q | i_rd_ready);
        // Refill stage 1 only when it will be free after this edge; this keeps
        // the RAM read register stable under backpressure.
        fetch   = (mem_cnt != '0) & (~p1_valid_q | adv);

        wr_ptr_d   = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PtrW'(fetch);
        mem_cnt_d  = wr_ptr_d - rd_ptr_d;
        p1_valid_d = fetch | (p1_valid_q & ~adv);

        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (adv) begin
            rd_valid_d = 1'b1;
            rd_data_d  = i_mem_rd_data;
        end else if (pop) begin
            rd_valid_d = 1'b0;
        end

        count_d = CntW'(mem_cnt_d) + CntW'(p1_valid_d) + CntW'(rd_valid_d);
    end

    // Flags and count are registered from next-state values so they always
    // describe the state left by the previous edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            p1_valid_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            p1_valid_q <= p1_valid_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            full_q     <= (mem_cnt_d == DepthPtr);
            afull_q    <= (mem_cnt_d >= AfullPtr);
            ovf_q      <= i_wr_en & full_q;
            count_q    <= count_d;
        end
    end

    assign o_full        = full_q;
    assign o_almost_full = afull_q;
    assign o_overflow    = ovf_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = rd_data_q;
    assign o_count       = count_q;

    assign o_mem_wr_en   = push_ok;
    assign o_mem_rd_en   = fetch;
    assign o_mem_full    = full_q;
    assign o_mem_wr_addr = wr_ptr_q[ADDR_BITS-1:0];
    assign o_mem_rd_addr = rd_ptr_q[ADDR_BITS-1:0];
    assign o_mem_wr_data = i_wr_data;

endmodule
